// File: rtl/time_char_streamer.sv
// time_char_streamer
//   Renders the packed BCD time word as the 8-character string "HH:MM:SS" and
//   streams it one character per valid/ready handshake to an LCD character
//   writer. The digit selected for editing blinks. A frame is sent only when
//   the rendered view (time, select, visible blink state) changes, plus once
//   after reset.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_time[19:0]  BCD time: [3:0] S1, [6:4] S2, [10:7] M1, [13:11] M2,
//                 [17:14] H1, [19:18] H2
//   i_time_sel    one-hot edit select (bit0=S1 .. bit5=H2), zero = no edit
//   i_char_ready  downstream accepts o_char this cycle
//   o_char_valid  o_char / o_char_pos valid
//   o_char        ASCII character
//   o_char_pos    column 0..7
//   o_frame_done  one-cycle pulse after the last character is accepted
module time_char_streamer #(
   parameter int unsigned CLOCK_FREQUENCY = 27000000,
   parameter int unsigned BLINK_HZ        = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [19:0] i_time,
   input  logic [5:0]  i_time_sel,
   input  logic        i_char_ready,
   output logic        o_char_valid,
   output logic [7:0]  o_char,
   output logic [2:0]  o_char_pos,
   output logic        o_frame_done
);

   localparam int unsigned HALF_RAW  = CLOCK_FREQUENCY / (2 * BLINK_HZ);
   localparam int unsigned HALF      = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int unsigned CW        = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t        state;
   logic [CW-1:0] blink_cnt;
   logic          blink_phase;
   logic [26:0]   view;
   logic [26:0]   snapshot;
   logic [26:0]   last_sent;
   logic          dirty;

   // The blink bit only counts while something is selected, so an idle blink
   // phase flip does not trigger a redundant frame.
   assign view = {i_time, i_time_sel, blink_phase & (|i_time_sel)};

   // Character for column p of a captured view {time, sel, blink}.
   function automatic logic [7:0] char_at(input logic [26:0] v, input logic [2:0] p);
      logic [19:0] t;
      logic [5:0]  s;
      logic        b;
      logic [3:0]  d;
      logic        sel_bit;
      logic        colon;
      logic [7:0]  c;
      t       = v[26:7];
      s       = v[6:1];
      b       = v[0];
      d       = '0;
      sel_bit = 1'b0;
      colon   = 1'b0;
      case (p)
         3'd0: begin d = {2'b00, t[19:18]}; sel_bit = s[5]; end
         3'd1: begin d = t[17:14];          sel_bit = s[4]; end
         3'd3: begin d = {1'b0, t[13:11]};  sel_bit = s[3]; end
         3'd4: begin d = t[10:7];           sel_bit = s[2]; end
         3'd6: begin d = {1'b0, t[6:4]};    sel_bit = s[1]; end
         3'd7: begin d = t[3:0];            sel_bit = s[0]; end
         default: colon = 1'b1;
      endcase
      if (colon)
         c = 8'h3A;
      else if (b && sel_bit)
         c = 8'h20;
      else if (d > 4'd9)
         c = 8'h3F;
      else
         c = {4'h3, d};
      return c;
   endfunction

   // Free-running blink timer, independent of the frame FSM.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == HALF_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         o_char_valid <= 1'b0;
         o_char       <= '0;
         o_char_pos   <= '0;
         o_frame_done <= 1'b0;
         dirty        <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               o_frame_done <= 1'b0;
               if (dirty || (view != last_sent)) begin
                  snapshot     <= view;
                  dirty        <= 1'b0;
                  o_char_pos   <= '0;
                  o_char       <= char_at(view, 3'd0);
                  o_char_valid <= 1'b1;
                  state        <= SEND;
               end
            end
            SEND: begin
               if (o_char_valid && i_char_ready) begin
                  if (o_char_pos == 3'd7) begin
                     o_char_valid <= 1'b0;
                     o_frame_done <= 1'b1;
                     state        <= DONE;
                  end else begin
                     o_char_pos <= o_char_pos + 3'd1;
                     o_char     <= char_at(snapshot, o_char_pos + 3'd1);
                  end
               end
            end
            DONE: begin
               o_frame_done <= 1'b0;
               last_sent    <= snapshot;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_time_char_streamer.sv
module tb_time_char_streamer;

   localparam int unsigned HALF = 4;  // CLOCK_FREQUENCY=8, BLINK_HZ=1

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] tm;
   logic [5:0]  sel;
   logic        ready;
   logic        o_char_valid;
   logic [7:0]  o_char;
   logic [2:0]  o_char_pos;
   logic        o_frame_done;

   always #5 clk = ~clk;

   time_char_streamer #(
      .CLOCK_FREQUENCY(8),
      .BLINK_HZ(1)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_time(tm),
      .i_time_sel(sel),
      .i_char_ready(ready),
      .o_char_valid(o_char_valid),
      .o_char(o_char),
      .o_char_pos(o_char_pos),
      .o_frame_done(o_frame_done)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference rendering of one column straight from the character map.
   function automatic logic [7:0] ref_char(input logic [19:0] t, input logic [5:0] s,
                                           input bit b, input int p);
      int unsigned vals[6];
      int idx;
      vals[0] = t[19:18];
      vals[1] = t[17:14];
      vals[2] = t[13:11];
      vals[3] = t[10:7];
      vals[4] = t[6:4];
      vals[5] = t[3:0];
      if (p == 2 || p == 5) return 8'h3A;
      idx = p - p / 3;
      if (b && s[5 - idx]) return 8'h20;
      if (vals[idx] > 9) return 8'h3F;
      return 8'(8'h30 + vals[idx]);
   endfunction

   // Transaction-level model state
   bit          m_busy, m_done, m_dirty;
   int          m_pos;
   int unsigned k;
   logic [26:0] m_last, m_snap;
   logic [19:0] m_t;
   logic [5:0]  m_s;
   bit          m_b;
   int          frames;
   logic [7:0]  s1_seen[$];
   logic [7:0]  acc[$];

   task automatic step();
      logic [19:0] t;
      logic [5:0]  s;
      bit          p_rst, p_ready, p_valid, ph, trig;
      logic [7:0]  p_char;
      logic [26:0] v;
      t = tm; s = sel; p_rst = rst; p_ready = ready;
      p_valid = o_char_valid; p_char = o_char;
      @(posedge clk);
      #1;
      if (p_rst) begin
         k = 0; m_busy = 0; m_done = 0; m_dirty = 1;
         check("reset_state", {o_char_valid, o_frame_done, o_char_pos, o_char}, '0);
         return;
      end
      if (p_valid && p_ready) acc.push_back(p_char);
      ph = ((k / HALF) % 2) == 1;
      k++;
      if (m_done) begin
         m_done = 0;
         m_last = m_snap;
         check("done_end", {o_char_valid, o_frame_done}, 2'b00);
      end else if (!m_busy) begin
         v = {t, s, ph && (s != 0)};
         trig = m_dirty || (v != m_last);
         if (trig) begin
            m_snap = v; m_dirty = 0; m_busy = 1; m_pos = 0;
            m_t = t; m_s = s; m_b = ph && (s != 0);
            check("frame_start", {o_char_valid, o_frame_done, o_char_pos, o_char},
                  {1'b1, 1'b0, 3'd0, ref_char(m_t, m_s, m_b, 0)});
         end else begin
            check("idle_quiet", {o_char_valid, o_frame_done}, 2'b00);
         end
      end else begin
         if (p_ready && m_pos == 7) begin
            m_busy = 0; m_done = 1; frames++;
            s1_seen.push_back(ref_char(m_t, m_s, m_b, 7));
            check("frame_done", {o_char_valid, o_frame_done}, 2'b01);
         end else begin
            if (p_ready) m_pos++;
            check("send_char", {o_char_valid, o_frame_done, o_char_pos, o_char},
                  {1'b1, 1'b0, 3'(m_pos), ref_char(m_t, m_s, m_b, m_pos)});
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      acc.delete();
      s1_seen.delete();
      frames = 0;
   endtask

   task automatic wait_pos(input int p, input string tag);
      int n;
      n = 0;
      while (!(o_char_valid && o_char_pos == 3'(p)) && n < 20) begin
         step();
         n++;
      end
      check(tag, {31'd0, o_char_valid && o_char_pos == 3'(p)}, 1);
   endtask

   logic [7:0] exp_str[8];
   logic [7:0] q;
   int n36, n20;

   initial begin
      exp_str = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36};
      rst = 1'b1; tm = 20'h49A56; sel = '0; ready = 1'b1;
      m_last = '0;

      // 1: basic frame, then silence while static
      do_reset();
      step();
      check("t1_latency", {31'd0, o_char_valid}, 1);
      repeat (10) step();
      check("t1_frames", frames, 1);
      check("t1_count", acc.size(), 8);
      for (int i = 0; i < 8; i++)
         check("t1_char", (acc.size() > i) ? acc[i] : 8'h00, exp_str[i]);
      repeat (20) step();
      check("t1_static", frames, 1);

      // 2: ready toggling
      do_reset();
      for (int i = 0; i < 24; i++) begin
         ready = (i % 2) == 0;
         step();
      end
      ready = 1'b1;
      repeat (4) step();
      check("t2_frames", frames, 1);
      check("t2_count", acc.size(), 8);
      for (int i = 0; i < 8; i++)
         check("t2_char", (acc.size() > i) ? acc[i] : 8'h00, exp_str[i]);

      // 3: blink on S1
      sel = 6'b000001;
      do_reset();
      repeat (60) step();
      n36 = 0; n20 = 0;
      foreach (s1_seen[i]) begin
         if (s1_seen[i] == 8'h36) n36++;
         if (s1_seen[i] == 8'h20) n20++;
      end
      check("t3_lit", {31'd0, n36 > 0}, 1);
      check("t3_blank", {31'd0, n20 > 0}, 1);
      check("t3_only", n36 + n20, s1_seen.size());

      // 4: time change mid-frame
      sel = '0; tm = 20'h49A56;
      do_reset();
      wait_pos(2, "t4_reach_pos2");
      tm = 20'h49A57;
      repeat (25) step();
      check("t4_frames", frames, 2);
      q = (s1_seen.size() > 0) ? s1_seen[0] : 8'h00;
      check("t4_first_s1", q, 8'h36);
      q = (s1_seen.size() > 1) ? s1_seen[1] : 8'h00;
      check("t4_second_s1", q, 8'h37);
      check("t4_last_char", (acc.size() > 15) ? acc[15] : 8'h00, 8'h37);

      // 5: invalid digit and hour edge values
      tm = {2'd3, 4'd9, 3'd3, 4'd4, 3'd5, 4'hB};
      do_reset();
      repeat (12) step();
      check("t5_h2", (acc.size() > 0) ? acc[0] : 8'h00, 8'h33);
      check("t5_h1", (acc.size() > 1) ? acc[1] : 8'h00, 8'h39);
      check("t5_s1", (acc.size() > 7) ? acc[7] : 8'h00, 8'h3F);

      // 6: reset mid-frame
      tm = 20'h49A56;
      do_reset();
      wait_pos(4, "t6_reach_pos4");
      do_reset();
      check("t6_no_done", {31'd0, o_frame_done}, 0);
      repeat (12) step();
      check("t6_frames", frames, 1);
      check("t6_count", acc.size(), 8);
      check("t6_first", (acc.size() > 0) ? acc[0] : 8'h00, 8'h31);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         ready = ($urandom % 4) != 0;
         if ($urandom % 20 == 0)
            tm = {2'($urandom), 4'($urandom), 3'($urandom), 4'($urandom), 3'($urandom), 4'($urandom)};
         if ($urandom % 40 == 0) begin
            case ($urandom % 3)
               0: sel = '0;
               1: sel = 6'(1 << ($urandom % 6));
               default: sel = 6'($urandom);
            endcase
         end
         rst = ($urandom % 250) == 0;
         step();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/time_char_streamer.md
Name: time_char_streamer

Overview:
- Read-side consumer of the clock_time packed BCD time word and digit-select vector.
- Renders the time as the 8-character ASCII string "HH:MM:SS" and streams it one character per handshake to the LCD character writer.
- The selected digit blinks while editing.
- A new frame is sent only when the rendered content changes.

Parameters:
- CLOCK_FREQUENCY, 27000000: i_clk frequency in Hz.
- BLINK_HZ, 2: blink rate of the selected digit in Hz. One full on+off period is 1/BLINK_HZ.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_time  in  20  packed BCD time: [3:0] S1, [6:4] S2, [10:7] M1, [13:11] M2, [17:14] H1, [19:18] H2.
- i_time_sel  in  6  one-hot edit select: bit0=S1, bit1=S2, bit2=M1, bit3=M2, bit4=H1, bit5=H2. All-zero means no edit, so no blink.
- i_char_ready  in  1  downstream accepts o_char this cycle.
- o_char_valid  out  1  o_char/o_char_pos are valid.
- o_char  out  8  ASCII character.
- o_char_pos  out  3  column 0..7.
- o_frame_done  out  1  one-cycle pulse after the last character of a frame is accepted.

Behaviour:
- Reset: the following are cleared to 0 on the clock edge where i_rst=1:
  - o_char_valid, o_char, o_char_pos, o_frame_done
  - blink counter and blink phase
  - FSM goes to IDLE.
  - A dirty flag is set, so one frame is always sent after reset.
- Reset mid-frame aborts the frame immediately: o_char_valid=0 the next cycle, and no o_frame_done.
- Blink timer:
  - HALF = max(1, CLOCK_FREQUENCY/(2*BLINK_HZ)).
  - The counter counts 0..HALF-1 and wraps. On each wrap, blink_phase toggles.
  - The timer runs free in all FSM states.
- Rendered view = {i_time, i_time_sel, blink_phase AND (i_time_sel != 0)}.
- FSM IDLE:
  - Leave IDLE when dirty=1, or when the rendered view differs from last_sent.
  - On leaving, capture the view into snapshot, clear dirty, and go to SEND with pos=0.
  - o_char_valid rises on the cycle after the trigger (latency 1).
- FSM SEND:
  - o_char_valid=1. o_char and o_char_pos are derived from snapshot and pos, and stay stable until the handshake.
  - Handshake = o_char_valid & i_char_ready on a rising edge.
  - pos<7: pos increments and the next character is presented the following cycle (back-to-back, no gap).
  - pos=7: go to DONE.
  - If i_char_ready is low, hold indefinitely with no timeout.
- FSM DONE:
  - o_char_valid=0, o_frame_done=1 for exactly one cycle.
  - last_sent <= snapshot; return to IDLE.
- Character map by pos: 0=H2, 1=H1, 2=':'(0x3A), 3=M2, 4=M1, 5=':', 6=S2, 7=S1.
- Digit encoding: 0x30 + value, zero-extended to 4 bits.
- A digit value >9 (only possible on 4-bit fields) sends '?' (0x3F).
- Blink: if the snapshot's blink bit=1 and that digit's sel bit=1, send space 0x20 instead of the digit. Colons never blink.
- Inputs that change during SEND/DONE are ignored for the current frame. IDLE sees the difference on its next cycle and starts a new frame, so no change is lost (last value wins).
- Blink toggling during a frame does not alter the current frame.
- i_time_sel with more than one bit set blanks every selected digit in the off phase.
- Minimum frame length: 8 SEND cycles + 1 DONE cycle + 1 IDLE cycle.

Test Plan:
1. Reset, then i_time=0x49A56 (12:34:56), sel=0, ready=1 -> valid rises 1 cycle after reset release; chars 0x31,0x32,0x3A,0x33,0x34,0x3A,0x35,0x36 on pos 0..7 in 8 consecutive cycles; o_frame_done pulses once; no further frame while inputs are static.
2. Same frame with ready toggling 1-0-1-0 -> each char held stable while ready=0; order and values unchanged; no char skipped or duplicated.
3. CLOCK_FREQUENCY=8, BLINK_HZ=1 (HALF=4), sel=6'b000001, time 12:34:56, ready=1 -> a new frame every phase flip; pos7 alternates 0x36 and 0x20; other columns unchanged.
4. Change i_time from 0x49A56 to 0x49A57 at the 3rd char of an ongoing frame -> current frame completes with pos7=0x36; the next frame starts right after o_frame_done and has pos7=0x37.
5. i_time[3:0]=4'hB -> pos7 = 0x3F. H2=3, H1=9 -> pos0/pos1 = 0x33/0x39.
6. Assert i_rst for 1 cycle mid-frame (pos=4) -> valid=0 the next cycle, no o_frame_done; after release, a full frame restarts from pos 0.
